aes_dec_round_ctrl: RTL
=======================

// Module: aes_dec_round_ctrl
// PURPOSE
//  Sequencing FSM for the iterative AES inverse-cipher datapath (AddRoundKey, InvShiftRows,
//  InvSubBytes, InvMixColumns, key expansion). Accepts one ciphertext/key job on a start strobe
//  and latches both. Drives round index, datapath mux selects and state-register enable for
//  NR+1 cycles, captures the plaintext and signals completion. Sits between the host and the datapath.
// PARAMETERS
//  NR   10  number of cipher rounds (10/12/14 for AES-128/192/256)
//  RW   4   width of round_idx / round counter; must hold NR
// PORTS
//  clk            in   1    single clock, all state on rising edge
//  reset          in   1    synchronous, active-high; clears all state
//  start          in   1    job request; accepted only when ready=1
//  data_in        in   128  ciphertext, sampled on accept
//  key_in         in   128  cipher key, sampled on accept
//  ready          out  1    FSM in IDLE, next start is accepted
//  busy           out  1    job in progress (INIT/ROUND/FINAL)
//  data_q         out  128  latched ciphertext to datapath input mux
//  key_q          out  128  latched key to key expansion
//  round_idx      out  RW   key-schedule round to apply: NR-cnt
//  ark_sel_data   out  1    1: AddRoundKey input = data_q; 0: = InvSubBytes output
//  sr_sel_mix     out  1    1: InvShiftRows input = InvMixColumns(state); 0: = state
//  state_en       out  1    load enable of datapath state register
//  result_in      in   128  datapath AddRoundKey output (combinational)
//  result_out     out  128  decrypted block, held until next capture
//  done           out  1    one-cycle pulse, result_out valid from this cycle on
// BEHAVIOUR
//  Reset (sync): state=IDLE, cnt=0, data_q/key_q/result_out=0, done=0, busy=0, ready=1,
//   state_en=0, ark_sel_data=0, sr_sel_mix=0, round_idx=NR. Reset mid-job aborts, no done.
//  States: IDLE -> INIT -> ROUND -> FINAL -> DONE -> IDLE.
//  IDLE: ready=1. start=1 at edge: latch data_q/key_q, cnt<=0, go INIT. start=0: stay.
//  INIT (cnt=0, 1 cycle): ark_sel_data=1, sr_sel_mix=0, round_idx=NR, state_en=1; cnt<=1 -> ROUND.
//  ROUND (cnt=1..NR-1): ark_sel_data=0, state_en=1, round_idx=NR-cnt;
//   sr_sel_mix=0 when cnt=1 (no InvMixColumns after initial ARK), else 1.
//   cnt increments each cycle; at cnt=NR-1 go FINAL.
//  FINAL (cnt=NR, 1 cycle): round_idx=0, sr_sel_mix=1, ark_sel_data=0, state_en=1;
//   result_out<=result_in at the closing edge; go DONE.
//  DONE (1 cycle): done=1, state_en=0; unconditionally -> IDLE.
//  Outside INIT/ROUND/FINAL: state_en=0, ark_sel_data=0, sr_sel_mix=0, round_idx=NR.
//  busy=1 exactly in INIT/ROUND/FINAL; ready=1 only in IDLE (not in DONE).
//  Latency: start accepted at edge E0 -> state_en high E0+1..E0+NR+1 (NR+1 cycles) ->
//   done high in cycle after edge E0+NR+1; ready again 1 cycle later. Period NR+3 cycles/job.
//  start while busy or in DONE: ignored, no queueing; data_in/key_in changes then have no effect.
//  start held high continuously: one job per NR+3 cycles, each latching the then-current inputs.
//  data_q/key_q stable for the entire job; result_out changes only at FINAL edge or reset.
//  cnt is RW bits, never exceeds NR; no wrap-around reachable.
//  All outputs registered or decoded from state/cnt only; no combinational path start->outputs
//   except none (ready depends on state only).
// TESTING
//  Bench pairs block with behavioural inverse-round datapath model; checks every cycle.
//  1 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a,
//    start 1 cycle -> done at E0+12, result_out=00112233445566778899aabbccddeeff.
//  2 Control trace, NR=10: round_idx 10,9..0 over 11 state_en cycles; ark_sel_data=1 only first;
//    sr_sel_mix=0 for first two enabled cycles, 1 for remaining nine.
//  3 start pulsed at E0+3 and in DONE cycle with different data -> ignored; result as test 1,
//    exactly one done pulse, data_q unchanged.
//  4 reset asserted at E0+5 -> next cycle ready=1, busy=0, result_out=0, no done;
//    new start afterwards decrypts correctly.
//  5 start held high 3 jobs, changing vectors -> done every 13 cycles, each result matches
//    vector latched at its own accept edge.
//  6 NR=14 build, FIPS-197 C.3 AES-256 vector (datapath with 256-bit key model) -> done at
//    E0+16, round_idx 14..0.

Source files
------------

// File: rtl/aes_dec_round_ctrl.sv
// Sequencer for an iterative AES inverse-cipher datapath: latches one ciphertext/key job,
// steps round index and mux selects for NR+1 cycles, then captures the plaintext.
//
// state   | meaning
// S_IDLE  | waiting for start, ready=1
// S_INIT  | initial AddRoundKey on latched ciphertext (round NR)
// S_ROUND | middle inverse rounds, cnt=1..NR-1
// S_FINAL | last round with round key 0, result captured at closing edge
// S_DONE  | one-cycle done pulse, start ignored
module aes_dec_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [127:0]  data_in,
  input  logic [127:0]  key_in,
  output logic          ready,
  output logic          busy,
  output logic [127:0]  data_q,
  output logic [127:0]  key_q,
  output logic [RW-1:0] round_idx,
  output logic          ark_sel_data,
  output logic          sr_sel_mix,
  output logic          state_en,
  input  logic [127:0]  result_in,
  output logic [127:0]  result_out,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [RW-1:0] NR_W   = RW'(NR);
  localparam logic [RW-1:0] LAST_W = RW'(NR - 1);
  localparam logic [RW-1:0] ONE_W  = RW'(1);

  state_e        state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          accept;

  assign accept = (state_q == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      key_q      <= '0;
      result_out <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        data_q <= data_in;
        key_q  <= key_in;
      end
      if (state_q == S_FINAL) begin
        result_out <= result_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      S_INIT: begin
        state_d = S_ROUND;
        cnt_d   = ONE_W;
      end
      S_ROUND: begin
        cnt_d = cnt_q + ONE_W;
        if (cnt_q == LAST_W) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode state/cnt only, so start has no combinational path to them.
  always_comb begin
    ready        = 1'b0;
    busy         = 1'b0;
    state_en     = 1'b0;
    ark_sel_data = 1'b0;
    sr_sel_mix   = 1'b0;
    round_idx    = NR_W;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
      end
      S_INIT: begin
        busy         = 1'b1;
        state_en     = 1'b1;
        ark_sel_data = 1'b1;
      end
      S_ROUND: begin
        busy       = 1'b1;
        state_en   = 1'b1;
        round_idx  = NR_W - cnt_q;
        sr_sel_mix = (cnt_q != ONE_W);
      end
      S_FINAL: begin
        busy       = 1'b1;
        state_en   = 1'b1;
        round_idx  = '0;
        sr_sel_mix = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule
